// File: rtl/sl_seq_pkg.sv
// sl_seq_pkg: shared types and sizes for the array command sequencer.
//   sl_seq_state_e : sequencer FSM states
//   SL_NUM_LINES   : converter lines scanned per read
//   SL_BYTE_W      : width of one DAC/ADC code
//   SL_RSP_W       : width of a packed read response
//   sl_max()       : elaboration-time max helper for counter sizing
package sl_seq_pkg;

  localparam int SL_NUM_LINES = 8;
  localparam int SL_BYTE_W    = 8;
  localparam int SL_RSP_W     = SL_NUM_LINES * SL_BYTE_W;
  localparam int SL_ADDR_W    = $clog2(SL_NUM_LINES);

  typedef enum logic [2:0] {
    IDLE,
    WR_LOAD,
    WR_DRIVE,
    RD_SETTLE,
    RD_LOCK,
    RD_SCAN,
    RSP
  } sl_seq_state_e;

  function automatic int sl_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sl_cycle_timer.sv
// sl_cycle_timer: loadable down-counter that times how long a state lasts.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   load, load_val     : load the cycle count on state entry
//   done               : high in the last cycle of the timed interval (count == 1)
// Loading N gives N cycles: the count reads N..1 and the owner leaves on 1.
module sl_cycle_timer #(
  parameter int CNT_W = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)            cnt_q <= '0;
    else if (load)             cnt_q <= load_val;
    else if (cnt_q != '0)      cnt_q <= cnt_q - CNT_W'(1);
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/sl_array_sequencer.sv
// sl_array_sequencer: turns byte-level write/read commands into the ordered
// mode / latch / data / address control of the 8-line array converter.
//   sys_clk, sys_rst_n          : clock, async active-low reset
//   cmd_valid/cmd_ready         : command handshake; cmd_write selects write,
//                                 cmd_data carries the DAC code
//   rsp_valid/rsp_ready/rsp_data: 64-bit read response, byte k = line k
//   busy                        : sequencer not idle
//   read_mode, adc_lock_en,
//   dac_lock_en, digital_data,
//   addr                        : converter controls (all registered)
//   digital_read                : ADC byte selected by addr
module sl_array_sequencer
  import sl_seq_pkg::*;
#(
  parameter int WR_PULSE_CYCLES  = 4,
  parameter int RD_SETTLE_CYCLES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [SL_BYTE_W-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [SL_RSP_W-1:0]  rsp_data,
  output logic                 busy,
  output logic                 read_mode,
  output logic                 adc_lock_en,
  output logic                 dac_lock_en,
  output logic [SL_BYTE_W-1:0] digital_data,
  output logic [SL_ADDR_W-1:0] addr,
  input  logic [SL_BYTE_W-1:0] digital_read
);

  localparam int DUR_W  = $clog2(sl_max(WR_PULSE_CYCLES, RD_SETTLE_CYCLES) + 1);
  localparam int SCAN_W = $clog2(SL_NUM_LINES + 1);
  localparam logic [DUR_W-1:0]  WR_LD   = DUR_W'(WR_PULSE_CYCLES);
  localparam logic [DUR_W-1:0]  RD_LD   = DUR_W'(RD_SETTLE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LD = SCAN_W'(SL_NUM_LINES);

  sl_seq_state_e state_q, state_d;

  logic             dur_load, dur_done;
  logic [DUR_W-1:0] dur_val;
  logic             scan_load, scan_done;

  logic [SL_NUM_LINES-1:0][SL_BYTE_W-1:0] rsp_q;

  // Duration timer shared by WR_DRIVE and RD_SETTLE (never active together);
  // the scan gets its own instance since 8 may exceed the duration width.
  sl_cycle_timer #(.CNT_W(DUR_W)) u_dur_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (dur_load),
    .load_val  (dur_val),
    .done      (dur_done)
  );

  sl_cycle_timer #(.CNT_W(SCAN_W)) u_scan_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (scan_load),
    .load_val  (SCAN_LD),
    .done      (scan_done)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state; timers are loaded on the edge that enters the timed state.
  always_comb begin
    state_d   = state_q;
    dur_load  = 1'b0;
    dur_val   = '0;
    scan_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            state_d = WR_LOAD;
          end else begin
            state_d  = RD_SETTLE;
            dur_load = 1'b1;
            dur_val  = RD_LD;
          end
        end
      end
      WR_LOAD: begin
        state_d  = WR_DRIVE;
        dur_load = 1'b1;
        dur_val  = WR_LD;
      end
      WR_DRIVE:  if (dur_done) state_d = IDLE;
      RD_SETTLE: if (dur_done) state_d = RD_LOCK;
      RD_LOCK: begin
        state_d   = RD_SCAN;
        scan_load = 1'b1;
      end
      RD_SCAN:   if (scan_done) state_d = RSP;
      RSP:       if (rsp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Every output is a flop decoded from the state being entered, so each
  // control lines up with its state cycle without combinational glitches.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      read_mode    <= 1'b1;
      adc_lock_en  <= 1'b0;
      dac_lock_en  <= 1'b0;
      rsp_valid    <= 1'b0;
      digital_data <= '0;
      addr         <= '0;
      rsp_q        <= '0;
    end else begin
      cmd_ready   <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      read_mode   <= !((state_d == WR_LOAD) || (state_d == WR_DRIVE));
      dac_lock_en <= (state_d == WR_LOAD);
      adc_lock_en <= (state_d == RD_LOCK);
      rsp_valid   <= (state_d == RSP);
      // addr is 0 on scan entry and steps once per scan cycle
      addr        <= ((state_q == RD_SCAN) && (state_d == RD_SCAN)) ?
                     addr + SL_ADDR_W'(1) : '0;
      if (state_d == WR_LOAD) digital_data <= cmd_data;
      // digital_read follows the registered addr, so byte k lands at the
      // end of the cycle that presents addr = k
      if (state_q == RD_SCAN) rsp_q[addr] <= digital_read;
    end
  end

  assign rsp_data = rsp_q;

endmodule

// File: tb/tb_sl_array_sequencer.sv
// tb_sl_array_sequencer: directed + randomized checks of two sequencer builds
// (W=4,R=2 and W=1,R=1). Expected per-cycle output values come from the
// command timeline (cycle index relative to the accepting edge) and from a
// converter memory model per instance.
module tb_sl_array_sequencer;
  import sl_seq_pkg::*;

  localparam int W0 = 4, R0 = 2, W1 = 1, R1 = 1;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic        cmd_valid [2], cmd_ready [2], cmd_write [2];
  logic        rsp_valid [2], rsp_ready [2], busy [2];
  logic        read_mode [2], adc_lock_en [2], dac_lock_en [2];
  logic [7:0]  cmd_data [2], digital_data [2], digital_read [2];
  logic [63:0] rsp_data [2];
  logic [2:0]  addr [2];

  logic [7:0]  mem [2][8];
  logic [7:0]  last_code [2];
  int checks = 0, failures = 0;

  assign digital_read[0] = mem[0][addr[0]];
  assign digital_read[1] = mem[1][addr[1]];

  sl_array_sequencer #(.WR_PULSE_CYCLES(W0), .RD_SETTLE_CYCLES(R0)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write[0]),
    .cmd_data(cmd_data[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]), .busy(busy[0]), .read_mode(read_mode[0]),
    .adc_lock_en(adc_lock_en[0]), .dac_lock_en(dac_lock_en[0]),
    .digital_data(digital_data[0]), .addr(addr[0]), .digital_read(digital_read[0])
  );

  sl_array_sequencer #(.WR_PULSE_CYCLES(W1), .RD_SETTLE_CYCLES(R1)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write[1]),
    .cmd_data(cmd_data[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]), .busy(busy[1]), .read_mode(read_mode[1]),
    .adc_lock_en(adc_lock_en[1]), .dac_lock_en(dac_lock_en[1]),
    .digital_data(digital_data[1]), .addr(addr[1]), .digital_read(digital_read[1])
  );

  task automatic chk(string tag, int u, int c, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d cyc%0d observed=%0h expected=%0h", tag, u, c, obs, exp);
    end
  endtask

  task automatic chk_outs(int u, int c, bit e_ready, bit e_busy, bit e_rm,
                          bit e_adc, bit e_dac, bit e_rv, logic [2:0] e_addr);
    chk("cmd_ready",    u, c, 64'(cmd_ready[u]),    64'(e_ready));
    chk("busy",         u, c, 64'(busy[u]),         64'(e_busy));
    chk("read_mode",    u, c, 64'(read_mode[u]),    64'(e_rm));
    chk("adc_lock_en",  u, c, 64'(adc_lock_en[u]),  64'(e_adc));
    chk("dac_lock_en",  u, c, 64'(dac_lock_en[u]),  64'(e_dac));
    chk("rsp_valid",    u, c, 64'(rsp_valid[u]),    64'(e_rv));
    chk("addr",         u, c, 64'(addr[u]),         64'(e_addr));
    chk("digital_data", u, c, 64'(digital_data[u]), 64'(last_code[u]));
    chk("strobe_excl",  u, c, 64'(dac_lock_en[u] & adc_lock_en[u]), 64'(0));
    chk("adc_in_rdmode", u, c, 64'(adc_lock_en[u] & ~read_mode[u]), 64'(0));
  endtask

  task automatic chk_reset(int u, int c);
    chk("rst_cmd_ready",    u, c, 64'(cmd_ready[u]),    64'(1));
    chk("rst_busy",         u, c, 64'(busy[u]),         64'(0));
    chk("rst_read_mode",    u, c, 64'(read_mode[u]),    64'(1));
    chk("rst_adc_lock_en",  u, c, 64'(adc_lock_en[u]),  64'(0));
    chk("rst_dac_lock_en",  u, c, 64'(dac_lock_en[u]),  64'(0));
    chk("rst_rsp_valid",    u, c, 64'(rsp_valid[u]),    64'(0));
    chk("rst_addr",         u, c, 64'(addr[u]),         64'(0));
    chk("rst_digital_data", u, c, 64'(digital_data[u]), 64'(0));
    chk("rst_rsp_data",     u, c, rsp_data[u],          64'(0));
  endtask

  // Called in the half cycle where the DUT is idle; that cycle becomes cycle 0.
  task automatic do_write(int u, logic [7:0] code);
    int w = (u != 0) ? W1 : W0;
    cmd_valid[u] = 1'b1; cmd_write[u] = 1'b1; cmd_data[u] = code;
    chk("wr_accept_ready", u, 0, 64'(cmd_ready[u]), 64'(1));
    @(posedge sys_clk); #1;
    cmd_valid[u] = 1'b0; cmd_data[u] = 8'($urandom);
    last_code[u] = code;
    for (int c = 1; c <= w + 2; c++) begin
      @(negedge sys_clk);
      chk_outs(u, c, c == w + 2, c <= w + 1, c > w + 1, 1'b0, c == 1, 1'b0, 3'd0);
    end
  endtask

  // hold: cycles rsp_ready stays low once rsp_valid is up.
  // offer: present a write (0x3C) while busy; caller must follow with do_write(u,8'h3C).
  // abort_c: cycle at which reset is asserted (-1 = none).
  task automatic do_read(int u, int hold, bit offer, int abort_c, bit ramp);
    int r = (u != 0) ? R1 : R0;
    logic [63:0] exp;
    for (int k = 0; k < 8; k++) begin
      mem[u][k] = ramp ? 8'(10 * (k + 1)) : 8'($urandom);
      exp[8*k +: 8] = mem[u][k];
    end
    cmd_valid[u] = 1'b1; cmd_write[u] = 1'b0; cmd_data[u] = 8'($urandom);
    rsp_ready[u] = (hold == 0);
    chk("rd_accept_ready", u, 0, 64'(cmd_ready[u]), 64'(1));
    @(posedge sys_clk); #1;
    cmd_valid[u] = 1'b0;
    for (int c = 1; c <= r + 10; c++) begin
      @(negedge sys_clk);
      chk_outs(u, c, 1'b0, 1'b1, 1'b1, c == r + 1, 1'b0, c == r + 10,
               (c >= r + 2 && c <= r + 9) ? 3'(c - r - 2) : 3'd0);
      if (c == abort_c) begin
        sys_rst_n = 1'b0;
        #1;
        last_code[0] = 8'h00; last_code[1] = 8'h00;
        chk_reset(u, c);
        return;
      end
    end
    chk("rsp_data", u, r + 10, rsp_data[u], exp);
    if (offer) begin
      cmd_valid[u] = 1'b1; cmd_write[u] = 1'b1; cmd_data[u] = 8'h3C;
    end
    for (int d = 1; d <= hold; d++) begin
      @(negedge sys_clk);
      chk("hold_rsp_valid", u, r + 10 + d, 64'(rsp_valid[u]), 64'(1));
      chk("hold_rsp_data",  u, r + 10 + d, rsp_data[u], exp);
      chk("hold_cmd_ready", u, r + 10 + d, 64'(cmd_ready[u]), 64'(0));
      chk("hold_busy",      u, r + 10 + d, 64'(busy[u]), 64'(1));
      if (d == hold) rsp_ready[u] = 1'b1;
    end
    @(negedge sys_clk);
    chk("post_rsp_valid", u, r + 11 + hold, 64'(rsp_valid[u]), 64'(0));
    chk("post_cmd_ready", u, r + 11 + hold, 64'(cmd_ready[u]), 64'(1));
    chk("post_busy",      u, r + 11 + hold, 64'(busy[u]), 64'(0));
    chk("post_rsp_data",  u, r + 11 + hold, rsp_data[u], exp);
    rsp_ready[u] = 1'b0;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      cmd_valid[u] = 1'b0; cmd_write[u] = 1'b0; cmd_data[u] = 8'h00;
      rsp_ready[u] = 1'b0; last_code[u] = 8'h00;
      for (int k = 0; k < 8; k++) mem[u][k] = 8'h00;
    end

    // reset state, then first command on the first edge after release
    repeat (3) @(negedge sys_clk);
    chk_reset(0, 0);
    chk_reset(1, 0);
    sys_rst_n = 1'b1;
    do_write(0, 8'hA5);

    // ramp pattern read, immediate consume
    do_read(0, 0, 1'b0, -1, 1'b1);

    // response held 5 cycles with a competing command offered
    do_read(0, 5, 1'b1, -1, 1'b0);
    do_write(0, 8'h3C);

    // write then immediate read: digital_data must stay 0x7F
    do_write(0, 8'h7F);
    do_read(0, 0, 1'b0, -1, 1'b0);

    // reset in the middle of the scan (addr = 3)
    do_read(0, 0, 1'b0, R0 + 5, 1'b0);
    repeat (2) begin
      @(negedge sys_clk);
      chk("rst_hold_rsp_valid", 0, 0, 64'(rsp_valid[0]), 64'(0));
      chk("rst_hold_read_mode", 0, 0, 64'(read_mode[0]), 64'(1));
    end
    sys_rst_n = 1'b1;
    do_read(0, 0, 1'b0, -1, 1'b0);

    // minimal-timing build
    do_write(1, 8'h5A);
    do_read(1, 0, 1'b0, -1, 1'b1);
    do_read(1, 2, 1'b1, -1, 1'b0);
    do_write(1, 8'h3C);

    // randomized command mix on both builds
    for (int i = 0; i < 40; i++) begin
      int u;
      u = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        do_write(u, 8'($urandom));
      end else begin
        bit off;
        off = 1'($urandom_range(0, 1));
        do_read(u, int'($urandom_range(0, 3)), off, -1, 1'b0);
        if (off) do_write(u, 8'h3C);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sl_array_sequencer.md
# sl_array_sequencer

Command sequencer directly upstream of the 8-line array converter interface. It accepts byte-level write and read commands over a valid/ready port and drives that interface's mode, latch-enable, data and address controls in the correct order. Reads return one 64-bit response holding the eight ADC bytes; writes drive the array bus for a programmable pulse width. It sits between the array control logic and the converter interface, and shares `sys_rst_n` with it.

## Interface
Parameters:
- `WR_PULSE_CYCLES`, default 4: cycles the DAC drives the bus after latching. Legal range ≥1.
- `RD_SETTLE_CYCLES`, default 2: cycles in read mode before the ADC latch strobe. Legal range ≥1.

Ports:
- `sys_clk`  in  1  sole clock; all logic is rising-edge.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_data`  in  8  DAC code for writes; ignored for reads.
- `rsp_valid`  out  1  read result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  64  byte k (bits 8k+7:8k) = ADC code of line k.
- `busy`  out  1  any state other than IDLE.
- `read_mode`  out  1  to the converter; 0 means the DAC drives the bus.
- `adc_lock_en`  out  1  ADC latch strobe.
- `dac_lock_en`  out  1  DAC latch strobe.
- `digital_data`  out  8  DAC code.
- `addr`  out  3  ADC byte select.
- `digital_read`  in  8  selected ADC byte; combinational from `addr`.

## Operation
- FSM states: IDLE, WR_LOAD, WR_DRIVE, RD_SETTLE, RD_LOCK, RD_SCAN, RSP.
- IDLE
  - `cmd_ready`=1 and `read_mode`=1, so the bus is never driven while idle.
  - Handshake `cmd_valid && cmd_ready` goes to WR_LOAD if `cmd_write`=1, otherwise RD_SETTLE.
- WR_LOAD (1 cycle)
  - `digital_data` = captured `cmd_data`; `dac_lock_en`=1; `read_mode`=0.
- WR_DRIVE (`WR_PULSE_CYCLES` cycles)
  - `read_mode`=0; then return to IDLE.
  - Writes produce no response.
- RD_SETTLE (`RD_SETTLE_CYCLES` cycles): `read_mode`=1.
- RD_LOCK (1 cycle): `adc_lock_en`=1.
- RD_SCAN (8 cycles)
  - `addr` = k in the k-th cycle.
  - `digital_read` is captured into byte k of the response register at the end of that cycle.
- RSP
  - `rsp_valid`=1 and `rsp_data` is held stable until `rsp_ready`=1; then return to IDLE.
  - `rsp_valid` drops the cycle after the handshake.
- Holding rules
  - `digital_data` holds the last written code until the next WR_LOAD. The converter's DAC latch is transparent while `dac_lock_en`=1.
  - `addr` returns to 0 outside RD_SCAN.
  - `rsp_data` holds its last value after the handshake.
- Strobes are mutually exclusive; `dac_lock_en` and `adc_lock_en` are never high together.
- All outputs are registered.

## Timing
- Command accepted at the edge ending cycle 0.
- Write
  - `dac_lock_en` is high in cycle 1.
  - `read_mode`=0 for cycles 1..W+1, where W = `WR_PULSE_CYCLES`.
  - `cmd_ready` returns in cycle W+2.
- Read
  - RD_SETTLE spans cycles 1..R, where R = `RD_SETTLE_CYCLES`.
  - `adc_lock_en` is high in cycle R+1.
  - `addr` steps 0..7 in cycles R+2..R+9.
  - `rsp_valid` rises in cycle R+10.
- Back-to-back: minimum gap is one IDLE cycle between commands.
- With `rsp_ready` held high, a read occupies R+11 cycles including the return to IDLE.
- `cmd_ready`=0 in every non-IDLE state. Commands offered then are not taken and must be held by the sender.
- Reset asserted, any state: all registers clear immediately.
  - Outputs: `read_mode`=1, all others 0, except `cmd_ready`=1, which rises asynchronously.
  - Any pending response is discarded.
- First command is accepted on the first edge after deassertion.
- Duration counter
  - Width is `$clog2(max(WR_PULSE_CYCLES, RD_SETTLE_CYCLES)+1)`.
  - Loaded on state entry; the state exits on the cycle the count reaches 1.

## Structure
- Package `sl_seq_pkg`:
  - FSM state enum `sl_seq_state_e`.
  - `SL_NUM_LINES`=8.
  - `SL_BYTE_W`=8.
  - `SL_RSP_W` = `SL_NUM_LINES*SL_BYTE_W`.
- Sub-module `sl_cycle_timer`: loadable down-counter with a `done` flag, used by WR_DRIVE, RD_SETTLE and RD_SCAN.

## Test plan
- Reset then write 0xA5, W=4
  - `dac_lock_en` is high exactly 1 cycle with `digital_data`=0xA5.
  - `read_mode`=0 for 5 cycles; `cmd_ready`=1 six cycles after the handshake.
  - No `rsp_valid`.
- Read with the converter model bus at line k = 10·(k+1), R=2
  - `adc_lock_en` is high in cycle 3; `addr` runs 0..7 in cycles 4..11.
  - `rsp_valid` rises in cycle 12.
  - Each `rsp_data` byte equals the model ADC code.
- Read with `rsp_ready` low for 5 cycles
  - `rsp_valid` and `rsp_data` are stable throughout.
  - A `cmd_valid` offered meanwhile is not accepted.
  - It is accepted one cycle after the response handshake.
- Write 0x7F then immediate read
  - `read_mode` is never 0 while `adc_lock_en`=1.
  - Strobes are never coincident.
  - `digital_data` stays 0x7F.
- Assert `sys_rst_n` in RD_SCAN at `addr`=3
  - All outputs reach reset values immediately (`read_mode`=1).
  - No response is issued.
  - After release, a fresh read completes normally.
- W=1, R=1 parameter build
  - Write occupies 3 cycles and read reaches `rsp_valid` at cycle 11.
